// File: rtl/multicycle_core_seq.sv
// Multi-cycle RV32I-style ALU sequencer: FETCH/DECODE/EXECUTE/WRITEBACK over a req/valid
// instruction-memory handshake, with an internal register file and integrated ALU.
module multicycle_core_seq #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned PC_RESET = 0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] pc_out
);

  localparam int unsigned RIW = $clog2(NREG);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] PcReset = XLEN'(PC_RESET);
  localparam logic [XLEN-1:0] PcStep  = XLEN'(PC_STEP);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFetch     = 3'd1;
  localparam logic [2:0] StDecode    = 3'd2;
  localparam logic [2:0] StExecute   = 3'd3;
  localparam logic [2:0] StWriteback = 3'd4;
  localparam logic [2:0] StHalt      = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] op_a_q, op_b_q, res_q;
  logic            illegal_q;
  logic [XLEN-1:0] regs [NREG];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            alt, is_r, is_i, is_ecall, dec_illegal;
  logic [RIW-1:0]  rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] imm, alu;
  logic [SHW-1:0]  shamt;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign alt      = instr_q[30];
  assign rd_idx   = instr_q[7 +: RIW];
  assign rs1_idx  = instr_q[15 +: RIW];
  assign rs2_idx  = instr_q[20 +: RIW];
  assign imm      = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign is_r     = (opcode == 7'h33);
  assign is_i     = (opcode == 7'h13);
  assign is_ecall = (opcode == 7'h73);

  // Unknown opcode, bad R-type funct7, or the alternate bit on an op that has no alternate form.
  assign dec_illegal = !(is_r || is_i || is_ecall)
                     || (is_r && (funct7 != 7'h00) && (funct7 != 7'h20))
                     || (is_r && alt && (funct3 != 3'd0) && (funct3 != 3'd5));

  assign shamt = op_b_q[SHW-1:0];

  always_comb begin
    alu = '0;
    case (funct3)
      3'd0: alu = (is_r && alt) ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
      3'd1: alu = op_a_q << shamt;
      3'd2: alu = {{(XLEN-1){1'b0}}, $signed(op_a_q) < $signed(op_b_q)};
      3'd3: alu = {{(XLEN-1){1'b0}}, op_a_q < op_b_q};
      3'd4: alu = op_a_q ^ op_b_q;
      3'd5: alu = alt ? $unsigned($signed(op_a_q) >>> shamt) : (op_a_q >> shamt);
      3'd6: alu = op_a_q | op_b_q;
      default: alu = op_a_q & op_b_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StHalt: if (start) state_d = StFetch;
      StFetch:        if (imem_valid) state_d = StDecode;
      StDecode:       state_d = (is_ecall || dec_illegal) ? StHalt : StExecute;
      StExecute:      state_d = StWriteback;
      StWriteback:    state_d = StFetch;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= PcReset;
      instr_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            pc_q      <= PcReset;
            illegal_q <= 1'b0;
          end
        end
        StFetch:     if (imem_valid) instr_q <= imem_rdata;
        StDecode: begin
          op_a_q <= regs[rs1_idx];
          op_b_q <= is_r ? regs[rs2_idx] : imm;
          if (dec_illegal) illegal_q <= 1'b1;
        end
        StExecute:   res_q <= alu;
        StWriteback: pc_q <= pc_q + PcStep;
        default: ;
      endcase
    end
  end

  // x0 is never written, so it reads back as its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[rd_idx] <= res_q;
    end
  end

  assign wb_en     = (state_q == StWriteback) && (rd_idx != '0);
  assign wb_addr   = wb_en ? instr_q[11:7] : 5'd0;
  assign wb_data   = wb_en ? res_q : '0;
  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign busy      = (state_q == StFetch) || (state_q == StDecode) ||
                     (state_q == StExecute) || (state_q == StWriteback);
  assign halted    = (state_q == StHalt);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_core_seq.sv
// Directed + random bench for multicycle_core_seq against an instruction-level reference model.
module tb_multicycle_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, busy, halted, illegal, wb_en;
  logic [31:0] imem_addr, wb_data, pc_out;
  logic [4:0]  wb_addr;

  multicycle_core_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  int          nerr = 0;
  int          nchk = 0;
  logic [31:0] mregs [32];
  logic [31:0] m_pc;
  logic [31:0] last_wb;
  logic        last_wb_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 retires normally, 1 ecall halt, 2 illegal halt
  task automatic model(input logic [31:0] ins, output int kind, output logic [31:0] res);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = mregs[ins[19:15]];
    b = (op == 7'h33) ? mregs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    res = '0;
    kind = 0;
    if (op == 7'h73) kind = 1;
    else if (op != 7'h33 && op != 7'h13) kind = 2;
    else if (op == 7'h33 && f7 != 7'h00 && f7 != 7'h20) kind = 2;
    else if (op == 7'h33 && ins[30] && f3 != 3'd0 && f3 != 3'd5) kind = 2;
    case (f3)
      3'd0: res = (op == 7'h33 && ins[30]) ? a - b : a + b;
      3'd1: res = a << b[4:0];
      3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: res = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: res = a | b;
      default: res = a & b;
    endcase
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 32'h0;
  endtask

  // Entered at a negedge where the core should be (or soon be) in FETCH.
  task automatic do_instr(input logic [31:0] ins, input int stall, input bit poke);
    int          guard;
    int          kind;
    logic [31:0] res;
    guard = 0;
    while (!imem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("fetch_req", imem_req, 1'b1);
    if (!imem_req) return;
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_pc", pc_out, m_pc);
    for (int s = 0; s < stall; s++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, m_pc);
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (poke) start = 1'b1;
    model(ins, kind, res);
    chk("dec_busy", busy, 1'b1);
    chk("dec_req", imem_req, 1'b0);
    @(negedge clk);
    start = 1'b0;
    last_wb_en = 1'b0;
    if (kind != 0) begin
      chk("halted", halted, 1'b1);
      chk("illegal", illegal, (kind == 2) ? 32'd1 : 32'd0);
      chk("halt_pc", pc_out, m_pc);
      chk("halt_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      chk("halt_req", imem_req, 1'b0);
      chk("halt_pc_frozen", pc_out, m_pc);
      chk("halt_no_wb", wb_en, 1'b0);
      return;
    end
    chk("exe_wb_en", wb_en, 1'b0);
    @(negedge clk);
    chk("wb_en", wb_en, (ins[11:7] != 5'd0) ? 32'd1 : 32'd0);
    last_wb_en = wb_en;
    last_wb = wb_data;
    if (ins[11:7] != 5'd0) begin
      chk("wb_addr", wb_addr, ins[11:7]);
      chk("wb_data", wb_data, res);
      mregs[ins[11:7]] = res;
    end
    m_pc = m_pc + 32'd4;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [6:0]  f7;
    f3 = 3'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return {f7, rs2, rs1, f3, rd, 7'h33};
    end
    imm = 12'($urandom);
    if (f3 == 3'd1) imm[11:5] = 7'h00;
    if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      do_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 1) == 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_illegal"}, illegal, 1'b0);
    chk({tag, "_wb_en"}, wb_en, 1'b0);
    chk({tag, "_wb_addr"}, wb_addr, 5'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_pc"}, pc_out, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_pc = 32'h0;
    last_wb = '0;
    last_wb_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    // Valid with no request outstanding must not start anything.
    imem_valid = 1'b1;
    imem_rdata = 32'h00500093;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_req", imem_req, 1'b0);

    pulse_start();
    do_instr(32'h00500093, 0, 1'b0);
    chk("t1_wb", last_wb, 32'd5);
    chk("t1_pc", pc_out, 32'd4);
    do_instr(32'hFFD00113, 0, 1'b1);
    chk("t2_x2", last_wb, 32'hFFFFFFFD);
    do_instr(32'h002081B3, 0, 1'b0);
    chk("t2_x3", last_wb, 32'd2);
    do_instr(32'h40208233, 0, 1'b1);
    chk("t2_x4", last_wb, 32'd8);
    do_instr(32'h40115293, 0, 1'b0);
    chk("t3_srai", last_wb, 32'hFFFFFFFE);
    do_instr(32'h00115293, 0, 1'b0);
    chk("t3_srli", last_wb, 32'h7FFFFFFE);
    do_instr(32'h00700013, 3, 1'b0);
    chk("t4_no_wb", last_wb_en, 1'b0);
    do_instr(32'h00000333, 0, 1'b0);
    chk("t4_x0_zero", last_wb, 32'd0);

    run_random(30);

    do_instr(32'h00000073, 0, 1'b0);
    pulse_start();
    chk("t5_restart_illegal", illegal, 1'b0);
    chk("t5_restart_addr", imem_addr, 32'd0);
    run_random(6);
    do_instr(32'h0000007F, 1, 1'b0);
    pulse_start();
    chk("t5_illegal_cleared", illegal, 1'b0);
    run_random(8);

    // Reset in the middle of a stalled fetch.
    chk("t6_fetch_req", imem_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("t6");
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_pc = 32'h0;
    @(negedge clk);
    chk_reset_outputs("t6_hold");
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    run_random(10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
